cpu_ad48_lsu: RTL
=================

CPU_AD48_LSU -- requirements
Module: cpu_ad48_lsu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be:
- DATA_W, 48, data word width
- ADDR_W, 48, address register width
- DISP_W, 33, signed displacement width
- MEM_AW, 7, word-address width of data memory
- LEN_W, 3, burst length field width (beats = cmd_len+1)
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk in 1: clock
- rst in 1: synchronous active-high reset
- cmd_valid in 1 / cmd_ready out 1: command handshake
- cmd_store in 1: 1=store, 0=load
- cmd_mode in 2: 00 OFFSET, 01 PRE_UPD, 10 POST_UPD, 11 treated as OFFSET
- cmd_base in ADDR_W / cmd_base_idx in 3: base value / base register index
- cmd_disp in DISP_W: signed displacement
- cmd_len in LEN_W: beats-1
- cmd_dst_idx in 3: first load destination register
- wd_valid in 1 / wd_ready out 1 / wd_data in DATA_W: store data stream
- rd_valid out 1 / rd_idx out 3 / rd_data out DATA_W / rd_last out 1: load results
- mem_req out 1 / mem_we out 1 / mem_addr out MEM_AW / mem_wdata out DATA_W / mem_gnt in 1: memory request
- mem_rvalid in 1 / mem_rdata in DATA_W: memory read response
- wb_valid out 1 / wb_idx out 3 / wb_addr out ADDR_W: base register writeback
- done out 1 / err out 1 / busy out 1: completion and error pulses, busy level

Function
REQ-004 FSM states SHALL be IDLE, CHECK, WDAT, REQ, RESP, WB, ERR.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command SHALL be captured on cmd_valid&&cmd_ready; busy SHALL be 1 in every state but IDLE.
REQ-006 Displacement SHALL be sign-extended to ADDR_W; sums SHALL wrap modulo 2^ADDR_W.
REQ-007 Start address SHALL be base+disp for OFFSET and PRE_UPD, base for POST_UPD; beat i address SHALL be start+i.
REQ-008 CHECK (one cycle) SHALL go to ERR if start[ADDR_W-1:MEM_AW] != 0 or start+cmd_len >= 2^MEM_AW (computed in ADDR_W+1 bits); else to WDAT (store) or REQ (load).
REQ-009 ERR SHALL pulse err and done for one cycle, issue no mem_req, no wb_valid, no rd_valid, then return to IDLE.
REQ-010 WDAT SHALL drive wd_ready=1; on wd_valid the word SHALL be latched and state SHALL go to REQ.
REQ-011 REQ SHALL hold mem_req=1 with mem_addr, mem_we=cmd_store, mem_wdata stable until the cycle mem_gnt=1; mem_gnt outside REQ SHALL be ignored.
REQ-012 On grant: store SHALL advance beat and go to WDAT, or to WB if last beat; load SHALL go to RESP.
REQ-013 RESP SHALL wait indefinitely for mem_rvalid; on it, mem_rdata SHALL be registered and presented next cycle as a one-cycle rd_valid, rd_idx=(cmd_dst_idx+i) mod 8, rd_last=1 on final beat; state SHALL go to REQ for the next beat or WB after the last.
REQ-014 mem_rvalid outside RESP SHALL be ignored.
REQ-015 WB SHALL pulse done for one cycle; wb_valid SHALL pulse in the same cycle with wb_idx=cmd_base_idx, wb_addr=base+disp, only if mode is PRE_UPD or POST_UPD and cmd_base_idx != 0; then IDLE.
REQ-016 Minimum latency: single load accepted at edge T -> mem_req in T+2 (after CHECK), rvalid T+3, rd_valid/done at T+4; single store with wd_valid and mem_gnt already high -> done at T+4.

Reset
REQ-017 On rst, state SHALL be IDLE next edge, mid-operation included; mem_req, wd_ready, rd_valid, wb_valid, done, err, busy SHALL be 0, cmd_ready SHALL be 1, data/address outputs SHALL be 0.
REQ-018 A mem_rvalid arriving after reset for a pre-reset request SHALL produce no rd_valid.

Verification
REQ-019 Memory preloaded MEM[k]=100*(k+1), k=0..8; load OFFSET base=2 disp=0 -> mem_addr 2, rd_data 300, rd_last 1, done at T+4, no wb_valid.
REQ-020 Load PRE_UPD base=2 idx=1 disp=2 -> mem_addr 4, rd_data 500, wb_valid idx 1 addr 4.
REQ-021 Store POST_UPD base=5 idx=2 disp=3 len=2, wd 11,22,33, mem_gnt stalled 2 cycles per beat -> MEM[5..7]=11,22,33, request fields stable during stall, wb addr 8.
REQ-022 Load len=1 dst_idx=7 base=0 -> rd_idx 7 then 0, data 100 then 200; PRE_UPD with base_idx=0 -> no wb_valid.
REQ-023 OFFSET base=0 disp=-1 -> err and done pulse, no mem_req; base=126 len=2 -> err.
REQ-024 rst during RESP -> IDLE next edge, mem_req 0, cmd_ready 1; subsequent mem_rvalid -> no rd_valid.

Source files
------------

// File: rtl/cpu_ad48_lsu_if.sv
// rtl/cpu_ad48_lsu_if.sv - command, store-data, load-result, memory and writeback bundle for the LSU
interface cpu_ad48_lsu_if #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 48,
  parameter int DISP_W = 33,
  parameter int MEM_AW = 7,
  parameter int LEN_W  = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_store;
  logic [1:0]        cmd_mode;
  logic [ADDR_W-1:0] cmd_base;
  logic [2:0]        cmd_base_idx;
  logic [DISP_W-1:0] cmd_disp;
  logic [LEN_W-1:0]  cmd_len;
  logic [2:0]        cmd_dst_idx;

  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;

  logic              rd_valid;
  logic [2:0]        rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic [2:0]        wb_idx;
  logic [ADDR_W-1:0] wb_addr;

  logic              done;
  logic              err;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_store, cmd_mode, cmd_base, cmd_base_idx, cmd_disp, cmd_len, cmd_dst_idx,
    output cmd_ready,
    input  wd_valid, wd_data,
    output wd_ready,
    output rd_valid, rd_idx, rd_data, rd_last,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output wb_valid, wb_idx, wb_addr,
    output done, err, busy
  );

  modport master (
    output cmd_valid, cmd_store, cmd_mode, cmd_base, cmd_base_idx, cmd_disp, cmd_len, cmd_dst_idx,
    input  cmd_ready,
    output wd_valid, wd_data,
    input  wd_ready,
    input  rd_valid, rd_idx, rd_data, rd_last,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  wb_valid, wb_idx, wb_addr,
    input  done, err, busy
  );
endinterface

// File: rtl/cpu_ad48_lsu.sv
// rtl/cpu_ad48_lsu.sv - burst load/store unit with offset, pre- and post-update addressing
module cpu_ad48_lsu #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 48,
  parameter int DISP_W = 33,
  parameter int MEM_AW = 7,
  parameter int LEN_W  = 3
) (
  input logic           clk,
  input logic           rst,
  cpu_ad48_lsu_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, WDAT, REQ, RESP, WB, ERR} state_t;

  state_t            state, state_nx;
  logic              store_r;
  logic              wb_en_r;
  logic [2:0]        base_idx_r;
  logic [2:0]        dst_idx_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  beat_r;
  logic [ADDR_W-1:0] start_r;
  logic [ADDR_W-1:0] upd_r;
  logic [DATA_W-1:0] wdata_r;
  logic              rd_valid_r;
  logic [2:0]        rd_idx_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_last_r;

  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] upd_sum;
  logic [ADDR_W-1:0] start_nx;
  logic              wb_en_nx;
  logic [ADDR_W:0]   end_sum;
  logic              range_err;
  logic              last_beat;
  logic [MEM_AW-1:0] beat_addr;

  assign disp_ext = {{(ADDR_W-DISP_W){bus.cmd_disp[DISP_W-1]}}, bus.cmd_disp};
  assign upd_sum  = bus.cmd_base + disp_ext;
  assign start_nx = (bus.cmd_mode == 2'b10) ? bus.cmd_base : upd_sum;
  assign wb_en_nx = ((bus.cmd_mode == 2'b01) || (bus.cmd_mode == 2'b10)) && (bus.cmd_base_idx != 3'd0);

  // One extra bit so a burst running past the top of the address space is caught, not wrapped
  assign end_sum   = {1'b0, start_r} + {{(ADDR_W+1-LEN_W){1'b0}}, len_r};
  assign range_err = (|start_r[ADDR_W-1:MEM_AW]) || (|end_sum[ADDR_W:MEM_AW]);
  assign last_beat = (beat_r == len_r);
  assign beat_addr = start_r[MEM_AW-1:0] + {{(MEM_AW-LEN_W){1'b0}}, beat_r};

  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_idx   = rd_idx_r;
  assign bus.rd_data  = rd_data_r;
  assign bus.rd_last  = rd_last_r;

  always_comb begin
    state_nx      = state;
    bus.cmd_ready = 1'b0;
    bus.wd_ready  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_idx    = '0;
    bus.wb_addr   = '0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nx = CHECK;
      end
      CHECK: begin
        if (range_err)    state_nx = ERR;
        else if (store_r) state_nx = WDAT;
        else              state_nx = REQ;
      end
      WDAT: begin
        bus.wd_ready = 1'b1;
        if (bus.wd_valid) state_nx = REQ;
      end
      REQ: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = store_r;
        bus.mem_addr  = beat_addr;
        bus.mem_wdata = store_r ? wdata_r : '0;
        if (bus.mem_gnt) begin
          if (!store_r)       state_nx = RESP;
          else if (last_beat) state_nx = WB;
          else                state_nx = WDAT;
        end
      end
      RESP: begin
        if (bus.mem_rvalid) state_nx = last_beat ? WB : REQ;
      end
      WB: begin
        bus.done = 1'b1;
        if (wb_en_r) begin
          bus.wb_valid = 1'b1;
          bus.wb_idx   = base_idx_r;
          bus.wb_addr  = upd_r;
        end
        state_nx = IDLE;
      end
      ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      store_r    <= 1'b0;
      wb_en_r    <= 1'b0;
      base_idx_r <= '0;
      dst_idx_r  <= '0;
      len_r      <= '0;
      beat_r     <= '0;
      start_r    <= '0;
      upd_r      <= '0;
      wdata_r    <= '0;
      rd_valid_r <= 1'b0;
      rd_idx_r   <= '0;
      rd_data_r  <= '0;
      rd_last_r  <= 1'b0;
    end else begin
      state      <= state_nx;
      rd_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            store_r    <= bus.cmd_store;
            wb_en_r    <= wb_en_nx;
            base_idx_r <= bus.cmd_base_idx;
            dst_idx_r  <= bus.cmd_dst_idx;
            len_r      <= bus.cmd_len;
            beat_r     <= '0;
            start_r    <= start_nx;
            upd_r      <= upd_sum;
          end
        end
        WDAT: begin
          if (bus.wd_valid) wdata_r <= bus.wd_data;
        end
        REQ: begin
          if (bus.mem_gnt && store_r && !last_beat) beat_r <= beat_r + 1'b1;
        end
        RESP: begin
          if (bus.mem_rvalid) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= bus.mem_rdata;
            rd_idx_r   <= dst_idx_r + 3'(beat_r);
            rd_last_r  <= last_beat;
            if (!last_beat) beat_r <= beat_r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
